// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_pkg;

    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;

    // Which requester owns the read data returning next cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_AUX
    } owner_t;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating aux wait counter: counts consecutive denied aux cycles and
// flags when the aux port has waited MAX_WAIT cycles.
module dmem_arb_wait_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= MAX_W);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the core's single-port synchronous data memory.
// Optional DMEM_ARB_STATS_EN adds stall_cycles / aux_grants counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   aux_grants
`endif
);

    logic   core_win;
    logic   aux_win;
    logic   wait_expired;
    owner_t rd_owner_q;
    owner_t rd_owner_d;

    dmem_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (aux_win || !aux_req),
        .inc     (aux_req && !aux_win),
        .expired (wait_expired)
    );

    always_comb begin
        core_win   = 1'b0;
        aux_win    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rd_owner_d = OWN_NONE;

        // A starved aux port overrides the core's default priority.
        if (aux_req && wait_expired) begin
            aux_win = 1'b1;
        end else if (core_req) begin
            core_win = 1'b1;
        end else if (aux_req) begin
            aux_win = 1'b1;
        end

        if (core_win) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            if (!core_we) begin
                rd_owner_d = OWN_CORE;
            end
        end else if (aux_win) begin
            mem_en    = 1'b1;
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            if (!aux_we) begin
                rd_owner_d = OWN_AUX;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign core_stall  = core_req && aux_win;
    assign aux_gnt     = aux_win;

    // rvalid decodes the registered owner so reset drops it without an edge.
    assign core_rvalid = (rd_owner_q == OWN_CORE);
    assign aux_rvalid  = (rd_owner_q == OWN_AUX);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign aux_rdata   = aux_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] aux_grants_q;
    logic [31:0] aux_grants_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + 32'(core_stall);
        aux_grants_d   = aux_grants_q + 32'(aux_win);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            aux_grants_q   <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            aux_grants_q   <= aux_grants_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign aux_grants   = aux_grants_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural synchronous memory
// and a read-return scoreboard.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic        core_stall, core_rvalid;
    logic [31:0] core_rdata;
    logic        aux_req, aux_we;
    logic [31:0] aux_addr, aux_wdata;
    logic        aux_gnt, aux_rvalid;
    logic [31:0] aux_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cycles, aux_grants;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int          due;
        bit          is_aux;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_gnt(aux_gnt),
        .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stall_cycles(stall_cycles), .aux_grants(aux_grants)
`endif
    );

    initial begin
        mem[16] <= 32'hDEADBEEF;
        mem[24] <= 32'h11112222;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    // Scoreboard: every cycle out of reset, rvalid/rdata must match the head entry.
    exp_t        mon_e;
    logic        mon_c, mon_a;
    logic [31:0] mon_d;
    always @(negedge clk) begin
        if (!reset) begin
            mon_c = 1'b0; mon_a = 1'b0; mon_d = 32'd0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                mon_c = !mon_e.is_aux;
                mon_a = mon_e.is_aux;
                mon_d = mon_e.data;
            end
            compared++;
            if (core_rvalid !== mon_c || aux_rvalid !== mon_a ||
                core_rdata !== (mon_c ? mon_d : 32'd0) ||
                aux_rdata !== (mon_a ? mon_d : 32'd0)) begin
                mismatched++;
                $display("FAIL rd_return cyc=%0d got core=%b/%h aux=%b/%h want core=%b aux=%b data=%h",
                         cyc, core_rvalid, core_rdata, aux_rvalid, aux_rdata, mon_c, mon_a, mon_d);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input bit is_aux, input logic [31:0] data);
        exp_t e;
        e.due = cyc + 1; e.is_aux = is_aux; e.data = data;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
        #2;
        compared++;
        if ({mem_en, mem_we, core_stall, aux_gnt} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl got en/we/stall/gnt=%b want 0000", {mem_en, mem_we, core_stall, aux_gnt});
        end
        compared++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        compared++;
        if ({core_rvalid, aux_rvalid} !== 2'b0 || core_rdata !== 32'd0 || aux_rdata !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_rvalid got %b%b %h %h want 0", core_rvalid, aux_rvalid, core_rdata, aux_rdata);
        end
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_core_store;
        core_req = 1; core_we = 1; core_addr = 32'd100; core_wdata = 32'd25;
        #1;
        compared++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd100 ||
            mem_wdata !== 32'd25 || core_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL core_store got en=%b we=%b addr=%0d wdata=%0d stall=%b want 1 1 100 25 0",
                     mem_en, mem_we, mem_addr, mem_wdata, core_stall);
        end
        tick;
    endtask

    task automatic test_core_load;
        core_req = 1; core_we = 0; core_addr = 32'd100;
        #1;
        compared++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd100) begin
            mismatched++;
            $display("FAIL core_load_issue got en=%b we=%b addr=%0d want 1 0 100", mem_en, mem_we, mem_addr);
        end
        push_read(1'b0, 32'd25);
        tick;
        core_req = 0;
        tick;
    endtask

    task automatic test_aux_read;
        aux_req = 1; aux_we = 0; aux_addr = 32'h40;
        #1;
        compared++;
        if (aux_gnt !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || core_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL aux_read_gnt got gnt=%b addr=%h we=%b stall=%b want 1 40 0 0",
                     aux_gnt, mem_addr, mem_we, core_stall);
        end
        push_read(1'b1, 32'hDEADBEEF);
        tick;
        aux_req = 0;
        tick;
    endtask

    task automatic test_contention;
        bit exp_aux;
        reset = 1'b1; #1; reset = 1'b0;
        sb.delete();
        core_req = 1; core_we = 0; core_addr = 32'd96;
        aux_req = 1; aux_we = 0; aux_addr = 32'h40;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_aux = (i % 5 == 4);
            compared++;
            if (aux_gnt !== exp_aux || core_stall !== exp_aux ||
                mem_addr !== (exp_aux ? 32'h40 : 32'd96)) begin
                mismatched++;
                $display("FAIL contention cycle=%0d got gnt=%b stall=%b addr=%h want gnt=stall=%b",
                         i + 1, aux_gnt, core_stall, mem_addr, exp_aux);
            end
            push_read(exp_aux, exp_aux ? 32'hDEADBEEF : 32'h11112222);
            tick;
        end
        core_req = 0; aux_req = 0;
        tick;
`ifdef DMEM_ARB_STATS_EN
        compared++;
        if (stall_cycles !== 32'd2 || aux_grants !== 32'd2) begin
            mismatched++;
            $display("FAIL stats got stall_cycles=%0d aux_grants=%0d want 2 2", stall_cycles, aux_grants);
        end
`endif
    endtask

    task automatic test_same_addr_store;
        core_req = 1; core_we = 1; core_addr = 32'd200; core_wdata = 32'h0000A5A5;
        aux_req = 1; aux_we = 1; aux_addr = 32'd200; aux_wdata = 32'h00005A5A;
        #1;
        compared++;
        if (aux_gnt !== 1'b0 || mem_wdata !== 32'h0000A5A5 || mem_we !== 1'b1) begin
            mismatched++;
            $display("FAIL dual_store got gnt=%b wdata=%h we=%b want 0 a5a5 1", aux_gnt, mem_wdata, mem_we);
        end
        tick;
        core_we = 0;
        #1;
        compared++;
        if (aux_gnt !== 1'b0 || mem_addr !== 32'd200) begin
            mismatched++;
            $display("FAIL dual_store_rd got gnt=%b addr=%0d want 0 200", aux_gnt, mem_addr);
        end
        push_read(1'b0, 32'h0000A5A5);
        tick;
        core_req = 0;
        #1;
        compared++;
        if (aux_gnt !== 1'b1 || mem_wdata !== 32'h00005A5A || mem_we !== 1'b1) begin
            mismatched++;
            $display("FAIL aux_store got gnt=%b wdata=%h we=%b want 1 5a5a 1", aux_gnt, mem_wdata, mem_we);
        end
        tick;
        aux_req = 0;
        core_req = 1; core_we = 0; core_addr = 32'd200;
        push_read(1'b0, 32'h00005A5A);
        tick;
        core_req = 0;
        tick;
    endtask

    task automatic test_reset_mid_read;
        core_req = 1; core_we = 0; core_addr = 32'd100;
        aux_req = 1; aux_we = 0; aux_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            push_read(1'b0, 32'd25);
            tick;
        end
        core_req = 0; aux_req = 0;
        #1;
        compared++;
        if (core_rvalid !== 1'b1 || core_rdata !== 32'd25) begin
            mismatched++;
            $display("FAIL pre_reset_rvalid got %b/%0d want 1/25", core_rvalid, core_rdata);
        end
        reset = 1'b1;
        sb.delete();
        #1;
        compared++;
        if (core_rvalid !== 1'b0 || core_rdata !== 32'd0 || mem_en !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_read got rvalid=%b rdata=%h en=%b want 0 0 0", core_rvalid, core_rdata, mem_en);
        end
        core_req = 1; aux_req = 1;
        #1;
        compared++;
        if (aux_gnt !== 1'b0 || core_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_wait_clear got gnt=%b stall=%b want 0 0", aux_gnt, core_stall);
        end
        core_req = 0; aux_req = 0;
        reset = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        test_reset;
        test_core_store;
        test_core_load;
        test_aux_read;
        test_contention;
        test_same_addr_store;
        test_reset_mid_read;
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory of the pipelined RISC-V core between two requesters.
- Requester 1 is the core's memory stage: DataAdr, WriteData, MemWrite plus a read request.
- Requester 2 is an auxiliary port: debug loader, DMA, or bench backdoor.
- Core has default priority. The aux port is protected from starvation by a wait counter. The arbiter stalls the core pipeline whenever the aux port owns the memory.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_WAIT, 4, consecutive denied aux cycles before aux is forced a grant (range 1..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- core_req  in  1  core memory-stage access valid this cycle.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  AW  byte address (DataAdr).
- core_wdata  in  DW  store data (WriteData).
- core_stall  out  1  core must hold its request and freeze the pipeline.
- core_rvalid  out  1  core load data valid.
- core_rdata  out  DW  core load data.
- aux_req  in  1  aux access valid; held until aux_gnt.
- aux_we  in  1  aux write enable.
- aux_addr  in  AW  aux address.
- aux_wdata  in  DW  aux write data.
- aux_gnt  out  1  aux access accepted this cycle.
- aux_rvalid  out  1  aux read data valid.
- aux_rdata  out  DW  aux read data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid one cycle after a read with mem_en=1.

Behaviour:
- Memory model: synchronous. Write completes at the edge. Read data appears on mem_rdata the cycle after issue.
- State: wait_cnt (4 bits), rd_owner (NONE/CORE/AUX, registered).
- Reset values: wait_cnt=0, rd_owner=NONE, core_rvalid=0, aux_rvalid=0. All combinational outputs are 0 with no requests.
- Grant (combinational, same cycle):
  - force_aux = aux_req && wait_cnt >= MAX_WAIT.
  - If force_aux: aux wins.
  - Else if core_req: core wins.
  - Else if aux_req: aux wins.
  - Else: no access.
- Winner's signals drive mem_*, with mem_en=1. With no winner: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- core_stall = core_req && aux wins. aux_gnt = aux wins.
- Loser holds its request stable. Changing a request while stalled or ungranted is a protocol violation; no defined response.
- wait_cnt:
  - Cleared on aux grant or when aux_req=0.
  - Incremented when aux_req && !aux_gnt.
  - Saturates at 15.
- rd_owner ← winner if the winning access is a read, else NONE.
- Next cycle after a read:
  - core_rvalid = (rd_owner==CORE), core_rdata = mem_rdata.
  - aux_rvalid = (rd_owner==AUX), aux_rdata = mem_rdata.
  - Each *_rdata is 0 when its rvalid is 0.
- Latency: grant 0 cycles; read data 1 cycle; throughput one access per cycle.
- Simultaneous requests with wait_cnt < MAX_WAIT: core wins, aux waits.
- Both stores to the same address in the same cycle: only the winner writes.
- Reset mid-read: rvalid drops immediately (asynchronous). The pending read is discarded.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stall_cycles (32, core_stall count) and aux_grants (32, aux_gnt count).
  - Both counters wrap at 2^32 and are cleared by reset.
- Undefined:
  - These ports and counters do not exist.
  - Arbitration behaviour is identical either way.

Decomposition:
- Shared package dmem_pkg: typedef enum owner_t {OWN_NONE, OWN_CORE, OWN_AUX}; default AW/DW localparams.
- One natural sub-module, dmem_arb_wait_ctr: saturating counter with clear/increment and a >= MAX_WAIT compare.

Test Plan:
- Core store, no aux:
  - Stimulus: core_req=1, core_we=1, core_addr=100, core_wdata=25.
  - Response: same cycle mem_en=1, mem_we=1, mem_addr=100, mem_wdata=25, core_stall=0.
- Core load after store:
  - Stimulus: core load from 100, following the previous store.
  - Response: next cycle core_rvalid=1, core_rdata=25, aux_rvalid=0.
- Contention:
  - Stimulus: core_req held 1 (loads from 96), aux_req held 1 (read 0x40), MAX_WAIT=4.
  - Response: aux_gnt=0 for cycles 1–4, aux_gnt=1 and core_stall=1 in cycle 5, then core resumes with wait_cnt=0.
- Aux read only:
  - Stimulus: aux read 0x40 with memory word 0xDEADBEEF.
  - Response: aux_gnt=1 same cycle; aux_rvalid=1, aux_rdata=0xDEADBEEF next cycle.
- Reset mid-operation:
  - Stimulus: assert reset between a core read issue and its return.
  - Response: core_rvalid=0 with no clock edge, wait_cnt=0, mem_en=0 while reset is held with no requests.
- Stats build (DMEM_ARB_STATS_EN):
  - Stimulus: the contention scenario run for 10 cycles.
  - Response: stall_cycles=2, aux_grants=2.
